// File: rtl/uc_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uc_multiciclo_pkg
// Description : Shared state encodings, opcodes and datapath select codes for
//               the multi-cycle MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package uc_multiciclo_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operation for the immediate-arithmetic family
    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        case (op)
            OP_ANDI: immAluOp = ALUOP_AND;
            OP_ORI:  immAluOp = ALUOP_OR;
            OP_SLTI: immAluOp = ALUOP_SLT;
            default: immAluOp = ALUOP_ADD;
        endcase
    endfunction

endpackage : uc_multiciclo_pkg
`default_nettype wire

// File: rtl/uc_multiciclo_dec.sv
`default_nettype none
// ============================================================================
// Module      : uc_multiciclo_dec
// Description : Combinational control-word decoder for the multi-cycle FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_multiciclo_dec
    import uc_multiciclo_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] OP,
    input  logic       MemReady,
    input  logic       ZF,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOP,
    output logic [1:0] PCSource,
    output logic       Halted
);

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOP       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        Halted      = 1'b0;

        case (state)
            S_FETCH: begin
                // IR and PC only latch once memory delivers the word
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: ALUSrcB = SRCB_IMMSH;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOP   = ALUOP_RTYPE;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOP   = immAluOp(OP);
            end
            S_IWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOP       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

    assign PCEn = PCWrite | (PCWriteCond & ZF);

endmodule : uc_multiciclo_dec
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : uc_multiciclo
// Description : Multi-cycle MIPS control unit: state register, sequencing and
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_multiciclo
    import uc_multiciclo_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       OP,
    input  logic             ZF,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOP,
    output logic [1:0]       PCSource,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    state_t           rState;
    state_t           wNextState;
    logic             wRetire;
    logic [CNT_W-1:0] rInstrCount;

    always_comb begin
        wNextState = rState;
        case (rState)
            S_IDLE:   wNextState = S_FETCH;
            S_FETCH:  wNextState = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OP)
                    OP_RTYPE:                           wNextState = S_EXEC;
                    OP_LW, OP_SW:                       wNextState = S_MEMADR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  wNextState = S_IEXEC;
                    OP_BEQ:                             wNextState = S_BRANCH;
                    OP_J:                               wNextState = S_JUMP;
                    default:                            wNextState = S_HALT;
                endcase
            end
            S_MEMADR: wNextState = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  wNextState = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  wNextState = S_FETCH;
            S_MEMWR:  wNextState = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   wNextState = S_RWB;
            S_RWB:    wNextState = S_FETCH;
            S_IEXEC:  wNextState = S_IWB;
            S_IWB:    wNextState = S_FETCH;
            S_BRANCH: wNextState = S_FETCH;
            S_JUMP:   wNextState = S_FETCH;
            S_HALT:   wNextState = S_HALT;
            // unused encodings fall into the trap state
            default:  wNextState = S_HALT;
        endcase
    end

    // An instruction retires on the edge leaving its final state
    always_comb begin
        case (rState)
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: wRetire = 1'b1;
            S_MEMWR:                                 wRetire = MemReady;
            default:                                 wRetire = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rState      <= S_IDLE;
            rInstrCount <= '0;
        end else begin
            rState <= wNextState;
            if (wRetire) begin
                rInstrCount <= rInstrCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign InstrCount = rInstrCount;
    assign State      = rState;

    uc_multiciclo_dec uDec (
        .state       (rState),
        .OP          (OP),
        .MemReady    (MemReady),
        .ZF          (ZF),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCEn        (PCEn),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOP       (ALUOP),
        .PCSource    (PCSource),
        .Halted      (Halted)
    );

endmodule : uc_multiciclo
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_multiciclo
// Description : Directed self-checking bench for the multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uc_multiciclo;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  OP;
    logic        ZF;
    logic        MemReady;

    logic        PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegWrite, RegDst, ALUSrcA, Halted;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOP;
    logic [31:0] InstrCount;
    logic [3:0]  State;

    logic        PCWrite4, PCWriteCond4, PCEn4, IorD4, MemRead4, MemWrite4, IRWrite4;
    logic        MemToReg4, RegWrite4, RegDst4, ALUSrcA4, Halted4;
    logic [1:0]  ALUSrcB4, PCSource4;
    logic [2:0]  ALUOP4;
    logic [3:0]  InstrCount4;
    logic [3:0]  State4;

    logic [18:0] ctrlVec;
    assign ctrlVec = {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
                      MemToReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOP, PCSource, Halted};

    int checks   = 0;
    int failures = 0;
    int irPulses = 0;

    always #5 CLK = ~CLK;

    uc_multiciclo dut (
        .CLK(CLK), .RST(RST), .OP(OP), .ZF(ZF), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOP(ALUOP), .PCSource(PCSource), .Halted(Halted), .InstrCount(InstrCount),
        .State(State)
    );

    uc_multiciclo #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .OP(OP), .ZF(ZF), .MemReady(MemReady),
        .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4), .PCEn(PCEn4), .IorD(IorD4),
        .MemRead(MemRead4), .MemWrite(MemWrite4), .IRWrite(IRWrite4), .MemToReg(MemToReg4),
        .RegWrite(RegWrite4), .RegDst(RegDst4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4),
        .ALUOP(ALUOP4), .PCSource(PCSource4), .Halted(Halted4), .InstrCount(InstrCount4),
        .State(State4)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive MemReady at the falling edge, then check the state
    task automatic cyc(input logic mr, input logic [3:0] expSt, input string tag);
        @(negedge CLK);
        MemReady = mr;
        #1;
        checkVal(tag, {28'd0, State}, {28'd0, expSt});
        if (IRWrite) irPulses++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; OP = 6'b000000; ZF = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        checkVal("rst_state", {28'd0, State}, 32'd0);
        checkVal("rst_ctrl", {13'd0, ctrlVec}, 32'd0);
        checkVal("rst_count", InstrCount, 32'd0);
        RST = 1'b0;

        // R-type, no stalls: 1,2,7,8,1
        cyc(1'b1, 4'd1, "r_fetch");
        checkVal("fetch_memread", {31'd0, MemRead}, 32'd1);
        cyc(1'b1, 4'd2, "r_decode");
        cyc(1'b1, 4'd7, "r_exec");
        checkVal("exec_regwrite", {31'd0, RegWrite}, 32'd0);
        checkVal("exec_aluop", {29'd0, ALUOP}, 32'd2);
        cyc(1'b0, 4'd8, "r_rwb");
        checkVal("rwb_regwrite", {31'd0, RegWrite}, 32'd1);
        checkVal("rwb_regdst", {31'd0, RegDst}, 32'd1);
        checkVal("rwb_count", InstrCount, 32'd0);
        OP = 6'b100011;

        // lw: 2 FETCH stalls, 3 MEMRD stalls, 10 cycles total
        irPulses = 0;
        cyc(1'b0, 4'd1, "lw_fetch0");
        checkVal("r_retired", InstrCount, 32'd1);
        checkVal("fetch_stall_ir", {31'd0, IRWrite}, 32'd0);
        cyc(1'b0, 4'd1, "lw_fetch1");
        cyc(1'b1, 4'd1, "lw_fetch2");
        checkVal("fetch_ready_ir", {31'd0, IRWrite}, 32'd1);
        checkVal("fetch_ready_pcen", {31'd0, PCEn}, 32'd1);
        cyc(1'b1, 4'd2, "lw_decode");
        cyc(1'b1, 4'd3, "lw_memadr");
        cyc(1'b0, 4'd4, "lw_memrd0");
        checkVal("memrd_ctrl", {30'd0, MemRead, IorD}, 32'd3);
        cyc(1'b0, 4'd4, "lw_memrd1");
        cyc(1'b0, 4'd4, "lw_memrd2");
        cyc(1'b1, 4'd4, "lw_memrd3");
        cyc(1'b1, 4'd5, "lw_memwb");
        checkVal("memwb_ctrl", {29'd0, MemToReg, RegWrite, RegDst}, 32'b110);
        checkVal("lw_ir_pulses", irPulses, 32'd1);
        cyc(1'b1, 4'd1, "lw_done");
        checkVal("lw_retired", InstrCount, 32'd2);
        OP = 6'b000100;

        // beq taken then not taken; both retire
        cyc(1'b1, 4'd2, "beq1_decode");
        ZF = 1'b1;
        cyc(1'b1, 4'd11, "beq1_branch");
        checkVal("beq_taken_pcen", {31'd0, PCEn}, 32'd1);
        checkVal("beq_pcsource", {30'd0, PCSource}, 32'd1);
        checkVal("beq_aluop", {29'd0, ALUOP}, 32'd1);
        cyc(1'b1, 4'd1, "beq1_done");
        checkVal("beq_taken_count", InstrCount, 32'd3);
        cyc(1'b1, 4'd2, "beq2_decode");
        ZF = 1'b0;
        cyc(1'b1, 4'd11, "beq2_branch");
        checkVal("beq_nottaken_pcen", {31'd0, PCEn}, 32'd0);
        cyc(1'b1, 4'd1, "beq2_done");
        checkVal("beq_nottaken_count", InstrCount, 32'd4);
        OP = 6'b101011;

        // sw with one MEMWR stall
        cyc(1'b1, 4'd2, "sw_decode");
        cyc(1'b1, 4'd3, "sw_memadr");
        cyc(1'b0, 4'd6, "sw_memwr0");
        checkVal("memwr_ctrl", {29'd0, MemWrite, IorD, MemRead}, 32'b110);
        checkVal("sw_stall_count", InstrCount, 32'd4);
        cyc(1'b1, 4'd6, "sw_memwr1");
        cyc(1'b1, 4'd1, "sw_done");
        checkVal("sw_count", InstrCount, 32'd5);
        OP = 6'b001101;

        // ori
        cyc(1'b1, 4'd2, "ori_decode");
        checkVal("decode_srcb", {30'd0, ALUSrcB}, 32'd3);
        cyc(1'b1, 4'd9, "ori_iexec");
        checkVal("ori_aluop", {29'd0, ALUOP}, 32'd4);
        checkVal("ori_srcb", {30'd0, ALUSrcB}, 32'd2);
        cyc(1'b1, 4'd10, "ori_iwb");
        checkVal("iwb_ctrl", {29'd0, RegWrite, RegDst, MemToReg}, 32'b100);
        cyc(1'b1, 4'd1, "ori_done");
        checkVal("ori_count", InstrCount, 32'd6);
        OP = 6'b100011;

        // reset in the middle of a lw memory read
        cyc(1'b1, 4'd2, "rstlw_decode");
        cyc(1'b1, 4'd3, "rstlw_memadr");
        cyc(1'b0, 4'd4, "rstlw_memrd");
        checkVal("rstlw_memread_pre", {31'd0, MemRead}, 32'd1);
        RST = 1'b1;
        #1;
        checkVal("rstlw_memread", {31'd0, MemRead}, 32'd0);
        checkVal("rstlw_state", {28'd0, State}, 32'd0);
        checkVal("rstlw_count", InstrCount, 32'd0);
        @(negedge CLK); #1;
        checkVal("rstlw_hold_ctrl", {13'd0, ctrlVec}, 32'd0);
        checkVal("rstlw_hold_count", InstrCount, 32'd0);
        RST = 1'b0;
        cyc(1'b1, 4'd1, "j_fetch0");
        OP = 6'b000010;

        // 16 jumps: 4-bit counter wraps to 0
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 4'd2, "j_decode");
            cyc(1'b1, 4'd12, "j_jump");
            if (k == 1) begin
                checkVal("j_ctrl", {29'd0, PCWrite, PCSource}, 32'b110);
            end
            cyc(1'b1, 4'd1, "j_fetch");
            checkVal("j_count4", {28'd0, InstrCount4}, k % 16);
            checkVal("j_count32", InstrCount, k);
        end
        OP = 6'b111111;

        // illegal opcode halts until reset
        cyc(1'b1, 4'd2, "halt_decode");
        cyc(1'b1, 4'd13, "halt_enter");
        checkVal("halt_ctrl", {13'd0, ctrlVec}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(i[0], 4'd13, "halt_stay");
            checkVal("halt_flag", {31'd0, Halted}, 32'd1);
            checkVal("halt_count", InstrCount, 32'd16);
        end
        checkVal("halt_count4", {28'd0, InstrCount4}, 32'd0);
        RST = 1'b1;
        #1;
        checkVal("halt_rst_flag", {31'd0, Halted}, 32'd0);
        checkVal("halt_rst_state", {28'd0, State}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uc_multiciclo
`default_nettype wire

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multi-cycle control FSM that sequences the MIPS datapath (PC, unified memory, BR, ALU, ALUControl, Mux-es) over several cycles per instruction. It replaces the single-cycle UC decoder.
- Decodes OP in DECODE, steps through the execute, memory and writeback states, and drives per-cycle control strobes.
- Waits on a memory ready handshake during memory accesses, halts on illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the InstrCount retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- OP  in  6  opcode, SalidaIR[31:26]; stable from the end of FETCH.
- ZF  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ZF.
- PCEn  out  1  PCWrite | (PCWriteCond & ZF).
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load instruction register.
- MemToReg  out  1  WD source: 1=MDR, 0=ALUOut.
- RegWrite  out  1  BR write enable.
- RegDst  out  1  WA: 1=rd[15:11], 0=rt[20:16].
- ALUSrcA  out  1  OP1: 0=PC, 1=DR1.
- ALUSrcB  out  2  OP2: 00=DR2, 01=const 4, 10=SignExt, 11=SignExt<<2.
- ALUOP  out  3  000 add, 001 sub, 010 R-type (funct), 011 and, 100 or, 101 slt.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- Halted  out  1  FSM in HALT.
- InstrCount  out  CNT_W  retired instruction count.
- State  out  4  current state encoding, for debug.

Behaviour:
- Reset
  - RST high: state=IDLE, InstrCount=0. Every output is 0 immediately (async), including strobes and Halted.
  - First edge after RST release: IDLE→FETCH.
- Outputs are decoded from state (Moore), except IRWrite, PCWrite and PCEn in FETCH, which are gated by MemReady (Mealy).
- Any output not listed for a state is 0.
- States, encoding, outputs and next state:
  - IDLE(0): all outputs 0 → FETCH.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSource=00, IRWrite=PCWrite=MemReady. Stay while !MemReady; else → DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOP=000. Next state by OP:
    - 000000 → EXEC
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) → IEXEC
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - any other → HALT
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOP=000 → MEMRD if lw, else MEMWR.
  - MEMRD(4): MemRead=1, IorD=1; hold until MemReady → MEMWB.
  - MEMWB(5): RegWrite=1, MemToReg=1, RegDst=0 → FETCH.
  - MEMWR(6): MemWrite=1, IorD=1; hold until MemReady → FETCH.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOP=010 → RWB.
  - RWB(8): RegWrite=1, RegDst=1, MemToReg=0 → FETCH.
  - IEXEC(9): ALUSrcA=1, ALUSrcB=10; ALUOP = addi 000, andi 011, ori 100, slti 101 → IWB.
  - IWB(10): RegWrite=1, RegDst=0, MemToReg=0 → FETCH.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUOP=001, PCWriteCond=1, PCSource=01 → FETCH.
  - JUMP(12): PCWrite=1, PCSource=10 → FETCH.
  - HALT(13): Halted=1, all other outputs 0. Sticky; only RST exits.
- Encodings 14–15 are unreachable; if entered, → HALT on the next edge.
- Retire: InstrCount increments on the edge that leaves MEMWB, RWB, IWB, BRANCH or JUMP, or that leaves MEMWR with MemReady=1.
  - A beq retires whether or not the branch is taken.
  - HALT never counts.
  - InstrCount wraps to 0 past all-ones.
- Cycle counts with MemReady=1: R/addi-family/sw 4, lw 5, beq/j 3. Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- RST asserted mid-access (any state): outputs drop to 0 combinationally and the memory transaction is abandoned.

Decomposition:
- Shared package uc_multiciclo_pkg holds:
  - the state encodings (4-bit, values above);
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI;
  - the ALUOP codes and the ALUSrcB/PCSource select codes, so ALUControl and the datapath muxes use the same values.
- One sub-module: uc_multiciclo_dec, purely combinational (state, OP, MemReady, ZF) → control word. The top module holds only the state register, next-state logic and InstrCount.

Test Plan:
- Reset with CLK running → all outputs 0 and State=0 while RST=1. One edge after release State=1, MemRead=1. Asserting RST mid-MEMRD → MemRead=0 immediately, InstrCount held at 0.
- R-type (OP=000000), MemReady=1 → State sequence 1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. InstrCount 0→1.
- lw with MemReady=0 for 2 cycles in FETCH and 3 cycles in MEMRD → FETCH lasts 3 cycles and IRWrite pulses once. MEMRD lasts 4 cycles. Total 10 cycles. MEMWB has MemToReg=1.
- beq in BRANCH: ZF=1 → PCEn=1, PCSource=01. ZF=0 → PCEn=0. InstrCount increments in both cases.
- OP=111111 → State 2→13, Halted=1. Further edges and MemReady toggling leave Halted=1 and InstrCount unchanged, until RST.
- CNT_W=4, 16 consecutive j instructions → InstrCount reads 15 after the 15th, then 0 after the 16th.
